lut_fifo_ctrl: RTL and testbench
================================

# lut_fifo_ctrl

Stream-side controller for the distributed LUT RAM: accepts a valid/ready input stream, writes words into the RAM, reads them back through the RAM's asynchronous read port, and presents them on a registered valid/ready output stream. It sits directly in front of and behind the LUT RAM, driving its write port and read address and consuming its read data. The LUT RAM is instantiated outside this block. Total capacity is 2^ADDR_WIDTH words in RAM plus one word in the output register.

## Interface
- DATA_WIDTH, 256, word width; must equal the RAM data width.
- ADDR_WIDTH, 5, RAM address width; RAM depth is 2^ADDR_WIDTH.
- ALMOST_FULL_THRESH, 2^ADDR_WIDTH-4, fill level at or above which almost_full asserts.

- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word.
- m_data  out  DATA_WIDTH  output word, registered.
- m_valid  out  1  output word valid, registered.
- m_ready  in  1  downstream accepts m_data.
- ram_wr_en  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_data_in  out  DATA_WIDTH  RAM write data; wired to s_data.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_data_out  in  DATA_WIDTH  RAM asynchronous read data.
- fill_level  out  ADDR_WIDTH+2  RAM occupancy plus m_valid.
- almost_full  out  1  fill_level >= ALMOST_FULL_THRESH.

## Operation
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, both reset to 0. The MSB is the wrap bit.
- RAM count is wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- ram_empty means the pointers are equal.
- ram_full means the low bits are equal and the MSBs differ.
- s_ready = !ram_full && !rst. It is derived from registers only and has no combinational path from m_ready.
- Push happens when s_valid && s_ready:
  - ram_wr_en = 1, ram_write_addr = wr_ptr[ADDR_WIDTH-1:0].
  - wr_ptr increments at the clock edge.
  - ram_wr_en is 0 whenever there is no push, including during rst.
- ram_read_addr = rd_ptr[ADDR_WIDTH-1:0] at all times.
- Load: when !ram_empty && (!m_valid || m_ready):
  - m_data <= ram_data_out, m_valid <= 1, rd_ptr increments.
- Pop without load: when m_valid && m_ready && ram_empty, m_valid <= 0. m_data holds its value.
- No bypass: a word always passes through the RAM, even when the FIFO is empty.
- Pointers wrap naturally at 2^(ADDR_WIDTH+1).
- fill_level and almost_full are combinational from the registered state.

## Timing
- Reset values: while rst is high at an edge, the pointers are cleared and m_valid <= 0. m_data resets to 0.
  - During rst: s_ready = 0, ram_wr_en = 0, fill_level = 0, almost_full = 0.
  - In the first cycle after rst deasserts: s_ready = 1.
- Latency: a word pushed in cycle N is written at the end of N and loaded at the end of N+1. m_valid is high in cycle N+2 when the output is empty and m_ready does not stall.
- Throughput: one word per cycle sustained in both directions.
- Full boundary: with RAM count = 2^ADDR_WIDTH, s_ready = 0 even when a load occurs in the same cycle. s_ready returns to 1 in the cycle after the load.
- Empty plus simultaneous push: the push is written to the RAM and no load happens that cycle.
- Push and load in the same cycle: both pointers advance. The write and read addresses never collide, because the RAM is neither full nor empty in that case.
- Reset mid-transfer: all contents are discarded. m_valid drops at the reset edge, and the handshake restarts cleanly.
- m_data is stable while m_valid && !m_ready.

## Test plan
- Reset: hold rst for 3 cycles with s_valid = 1 -> ram_wr_en = 0, s_ready = 0, m_valid = 0, fill_level = 0. After release, s_ready = 1.
- Single word: push 0xA5 in cycle N with m_ready = 1 -> ram_write_addr = 0 in N, m_valid = 1 and m_data = 0xA5 in N+2, fill_level returns to 0 in N+3.
- Fill with ADDR_WIDTH = 5 and m_ready = 0: push 40 sequential words -> 33 accepted (32 in RAM plus 1 in the output register), s_ready = 0 from the 33rd accepted push onward, fill_level = 33, almost_full set at fill_level 28.
- Drain after fill: raise m_ready -> 33 words out in order 0..32, one per cycle. s_ready reasserts the cycle after the first load.
- Wrap: stream 200 words with m_ready toggled at random and s_valid at random -> output equals input order, no loss or duplication, pointers wrap several times.
- Reset mid-stream: assert rst with fill_level = 10 -> m_valid = 0 after the edge. Words pushed afterward emerge starting at RAM address 0.

Source files
------------

// File: rtl/lut_fifo_ctrl_if.sv
// rtl/lut_fifo_ctrl_if.sv - input and output valid/ready streams of the LUT RAM FIFO controller
interface lut_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 256
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   // Producer/consumer side: drives the input stream, accepts the output stream
   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid
   );

   // Controller side
   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid
   );
endinterface

// File: rtl/lut_fifo_ctrl.sv
// rtl/lut_fifo_ctrl.sv - stream controller wrapped around an external LUT RAM with async read
module lut_fifo_ctrl #(
   parameter int DATA_WIDTH         = 256,
   parameter int ADDR_WIDTH         = 5,
   parameter int ALMOST_FULL_THRESH = (2 ** ADDR_WIDTH) - 4
) (
   input  logic                  clk,
   input  logic                  rst,
   lut_fifo_ctrl_if.slave        bus,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic [ADDR_WIDTH+1:0] fill_level,
   output logic                  almost_full
);

   localparam logic [ADDR_WIDTH+1:0] AF_THRESH = (ADDR_WIDTH+2)'(ALMOST_FULL_THRESH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   ram_count;
   logic                  ram_empty;
   logic                  ram_full;
   logic                  push;
   logic                  load;
   logic                  m_valid_r;
   logic [DATA_WIDTH-1:0] m_data_r;

   assign ram_count = wr_ptr - rd_ptr;
   assign ram_empty = (wr_ptr == rd_ptr);
   assign ram_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

   // s_ready depends only on the pointers, so a load in the same cycle as a
   // full RAM does not open the input until the following cycle.
   assign bus.s_ready = !ram_full && !rst;
   assign push        = bus.s_valid && bus.s_ready;

   // Every word goes through the RAM; the output register only ever loads
   // from the async read port, never directly from s_data.
   assign load = !ram_empty && (!m_valid_r || bus.m_ready);

   assign ram_wr_en      = push;
   assign ram_write_addr = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_data_in    = bus.s_data;
   assign ram_read_addr  = rd_ptr[ADDR_WIDTH-1:0];

   assign bus.m_valid = m_valid_r;
   assign bus.m_data  = m_data_r;

   // Occupancy counts the output register as one extra slot.
   assign fill_level  = rst ? '0 : ({1'b0, ram_count} + (ADDR_WIDTH+2)'(m_valid_r));
   assign almost_full = !rst && (fill_level >= AF_THRESH);

   // Write pointer advances on every accepted input word
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Output register: refill from RAM when empty or being consumed, else drop valid on pop
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         m_valid_r <= 1'b0;
         m_data_r  <= '0;
      end else if (load) begin
         rd_ptr    <= rd_ptr + 1'b1;
         m_valid_r <= 1'b1;
         m_data_r  <= ram_data_out;
      end else if (m_valid_r && bus.m_ready) begin
         m_valid_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lut_fifo_ctrl.sv
// tb/tb_lut_fifo_ctrl.sv - directed and scoreboarded stimulus for lut_fifo_ctrl
module tb_lut_fifo_ctrl;

   localparam int DW = 256;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          ram_wr_en;
   logic [AW-1:0] ram_write_addr;
   logic [DW-1:0] ram_data_in;
   logic [AW-1:0] ram_read_addr;
   logic [DW-1:0] ram_data_out;
   logic [AW+1:0] fill_level;
   logic          almost_full;

   int n_cmp = 0;
   int n_err = 0;

   lut_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   lut_fifo_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .ALMOST_FULL_THRESH(28)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .ram_wr_en(ram_wr_en),
      .ram_write_addr(ram_write_addr),
      .ram_data_in(ram_data_in),
      .ram_read_addr(ram_read_addr),
      .ram_data_out(ram_data_out),
      .fill_level(fill_level),
      .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   // External LUT RAM: synchronous write, asynchronous read
   logic [DW-1:0] mem [0:(2**AW)-1];
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_write_addr] <= ram_data_in;
   end
   assign ram_data_out = mem[ram_read_addr];

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int            accepted;
   logic [DW-1:0] next_word;
   logic [DW-1:0] cur_word;
   logic [DW-1:0] prev_data;
   logic          prev_hold;
   logic [DW-1:0] q [$];
   int            sent, rcvd, cyc;

   initial begin
      rst         = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      // Reset held for three cycles with s_valid high
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("rst_wr_en", ram_wr_en, 0);
         chk("rst_s_ready", bus.s_ready, 0);
         chk("rst_m_valid", bus.m_valid, 0);
         chk("rst_fill", fill_level, 0);
         chk("rst_af", almost_full, 0);
      end
      rst         = 1'b0;
      bus.s_valid = 1'b0;
      #1;
      chk("rel_s_ready", bus.s_ready, 1);
      tick();

      // Single word through the RAM
      bus.s_valid = 1'b1;
      bus.s_data  = 256'hA5;
      bus.m_ready = 1'b1;
      #1;
      chk("one_wr_en", ram_wr_en, 1);
      chk("one_waddr", ram_write_addr, 0);
      tick();
      bus.s_valid = 1'b0;
      #1;
      chk("one_n1_valid", bus.m_valid, 0);
      chk("one_n1_fill", fill_level, 1);
      tick();
      #1;
      chk("one_n2_valid", bus.m_valid, 1);
      chk("one_n2_data", bus.m_data, 256'hA5);
      chk("one_n2_fill", fill_level, 1);
      tick();
      #1;
      chk("one_n3_fill", fill_level, 0);
      chk("one_n3_valid", bus.m_valid, 0);

      // Fill with the output stalled: 32 in RAM + 1 in the output register
      bus.m_ready = 1'b0;
      accepted    = 0;
      next_word   = '0;
      for (int i = 0; i < 40; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = next_word;
         #1;
         chk("fill_level", fill_level, accepted);
         chk("fill_af", almost_full, (accepted >= 28) ? 1 : 0);
         chk("fill_s_ready", bus.s_ready, (accepted < 33) ? 1 : 0);
         if (bus.s_ready) begin
            accepted++;
            next_word = next_word + 1;
         end
         tick();
      end
      bus.s_valid = 1'b0;
      #1;
      chk("fill_accepted", accepted, 33);
      chk("fill_final", fill_level, 33);
      chk("fill_final_af", almost_full, 1);

      // Drain in order, one per cycle; input reopens the cycle after the first load
      for (int d = 0; d < 33; d++) begin
         bus.m_ready = 1'b1;
         #1;
         chk("drain_valid", bus.m_valid, 1);
         chk("drain_data", bus.m_data, d);
         if (d == 0) chk("drain_s_ready0", bus.s_ready, 0);
         if (d == 1) chk("drain_s_ready1", bus.s_ready, 1);
         tick();
      end
      #1;
      chk("drain_end_valid", bus.m_valid, 0);
      chk("drain_end_fill", fill_level, 0);

      // Random streaming with wrap-around, scoreboarded
      sent      = 0;
      rcvd      = 0;
      cyc       = 0;
      prev_hold = 1'b0;
      prev_data = '0;
      cur_word  = {8{$urandom}};
      while ((sent < 200 || rcvd < 200) && cyc < 4000) begin
         bus.s_valid = (sent < 200) && ($urandom_range(0, 1) == 1);
         bus.s_data  = cur_word;
         bus.m_ready = ($urandom_range(0, 1) == 1);
         #1;
         chk("wrap_fill", fill_level, q.size());
         if (prev_hold) begin
            chk("hold_valid", bus.m_valid, 1);
            chk("hold_data", bus.m_data, prev_data);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (q.size() == 0) chk("wrap_extra", 1, 0);
            else chk("wrap_data", bus.m_data, q.pop_front());
            rcvd++;
         end
         if (bus.s_valid && bus.s_ready) begin
            q.push_back(cur_word);
            sent++;
            cur_word = {8{$urandom}};
         end
         prev_hold = bus.m_valid && !bus.m_ready;
         prev_data = bus.m_data;
         tick();
         cyc++;
      end
      chk("wrap_sent", sent, 200);
      chk("wrap_rcvd", rcvd, 200);
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;

      // Reset in the middle of a stream with ten words held
      for (int i = 0; i < 10; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 256'(100 + i);
         tick();
      end
      bus.s_valid = 1'b0;
      #1;
      chk("mid_fill", fill_level, 10);
      rst = 1'b1;
      tick();
      #1;
      chk("mid_rst_valid", bus.m_valid, 0);
      chk("mid_rst_fill", fill_level, 0);
      rst         = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 256'h55;
      #1;
      chk("mid_s_ready", bus.s_ready, 1);
      chk("mid_wr_en", ram_wr_en, 1);
      chk("mid_waddr", ram_write_addr, 0);
      tick();
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      #1;
      chk("mid_raddr", ram_read_addr, 0);
      tick();
      #1;
      chk("mid_out_valid", bus.m_valid, 1);
      chk("mid_out_data", bus.m_data, 256'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
